// File: rtl/mcu_spi_target.sv
// -----------------------------------------------------------------------------
// mcu_spi_target
//
// SPI (mode 0, MSB first) target that sits between an MCU and up to four
// on-chip byte consumers. The first byte of each frame selects the target
// (0..3). The second byte is delivered as a "command" byte (data_in_start=1).
// Every later byte is delivered as payload. An address of 4 or more drops the
// rest of the frame. The reply byte for each slot is taken from the selected
// target's data_out bus and shifted out on MISO.
//
// All SPI pins are asynchronous to clk. Each pin passes a 2-flop synchronizer,
// and SCK edges are detected on the synchronized samples. clk must run at
// least 8x the SCK frequency.
//
// Optional build macro:
//   MCU_SPI_TIMEOUT_EN - adds a 16-bit watchdog that aborts a byte stalled
//                        mid-transfer. When the watchdog fires, frame_err
//                        pulses and the frame is dropped. When the macro is
//                        undefined, frame_err is tied low.
//
// Ports:
//   clk             system clock
//   reset           synchronous active-high reset
//   spi_io_ss       chip select, active low (async)
//   spi_io_clk      SPI clock (async)
//   spi_io_din      MOSI (async)
//   spi_io_dout     MISO
//   data_in_strobe  one-hot, one-cycle byte strobe per target 0..3
//   data_in_start   1 = strobed byte is the first payload byte of the frame
//   data_in         received payload byte
//   data_out0..3    reply byte presented by each target
//   frame_err       one-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module mcu_spi_target (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_io_ss,
    input  logic       spi_io_clk,
    input  logic       spi_io_din,
    output logic       spi_io_dout,
    output logic [3:0] data_in_strobe,
    output logic       data_in_start,
    output logic [7:0] data_in,
    input  logic [7:0] data_out0,
    input  logic [7:0] data_out1,
    input  logic [7:0] data_out2,
    input  logic [7:0] data_out3,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_FIRST,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    // Synchronizers plus one extra stage per edge-detected line.
    logic ss_meta_q, ss_sync_q, ss_prev_q;
    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic din_meta_q, din_sync_q;

    // After reset the synchronizer chain still holds its idle levels for a
    // few cycles. SS falling edges are only accepted once SS has actually
    // been seen high on live samples. Without this, a chip select held low
    // through reset would look like a fresh frame start.
    logic [1:0] settle_q;
    logic       armed_q;

    state_t     state_q;
    state_t     done_state_q;
    logic       byte_done_q;
    logic [7:0] rx_shift_q;
    logic [7:0] rx_shift_d;
    logic [7:0] rx_byte_q;
    logic [2:0] bit_cnt_q;
    logic [1:0] target_q;
    logic [7:0] tx_shift_q;
    logic [7:0] tx_shift_d;
    logic [3:0] strobe_q;
    logic       start_q;
    logic [7:0] data_q;

    logic       sck_rise, sck_fall, ss_rise, ss_fall;
    logic       rx_take;
    logic [3:0] target_onehot;
    logic [7:0] reply_sel;
    logic [7:0] reload_byte;

    assign sck_rise = sck_sync_q & ~sck_prev_q;
    assign sck_fall = ~sck_sync_q & sck_prev_q;
    assign ss_rise  = ss_sync_q & ~ss_prev_q;
    assign ss_fall  = ~ss_sync_q & ss_prev_q;

    // Bits are taken in any in-frame state. This also covers the cycle in
    // which SS is seen rising: an SCK edge detected together with SS release
    // still completes its byte.
    assign rx_take    = sck_rise && (state_q != ST_IDLE);
    assign rx_shift_d = {rx_shift_q[6:0], din_sync_q};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
            assign target_onehot[gi] = (target_q == 2'(gi));
        end
    endgenerate

    always_comb begin
        reply_sel = data_out0;
        case (target_q)
            2'd0: reply_sel = data_out0;
            2'd1: reply_sel = data_out1;
            2'd2: reply_sel = data_out2;
            2'd3: reply_sel = data_out3;
            default: reply_sel = data_out0;
        endcase
    end

    // Only frames addressed to a valid target reply. The address slot and
    // dropped frames send zeros.
    assign reload_byte = ((state_q == ST_FIRST) || (state_q == ST_PAYLOAD)) ? reply_sel : 8'h00;

    // Between bytes, keep tracking the target's reply so that the freshest
    // value is loaded before the first rising edge. Within a byte, shift on
    // each falling edge.
    always_comb begin
        tx_shift_d = tx_shift_q;
        if ((bit_cnt_q == 3'd0) && !sck_sync_q) begin
            tx_shift_d = reload_byte;
        end else if (sck_fall && (bit_cnt_q != 3'd0)) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end
    end

`ifdef MCU_SPI_TIMEOUT_EN
    logic [15:0] wd_q;
    logic        frame_err_q;
    logic        wd_timeout;
    assign wd_timeout = (wd_q == 16'hFFFF);
    assign frame_err  = frame_err_q;
`else
    assign frame_err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ss_meta_q    <= 1'b1;
            ss_sync_q    <= 1'b1;
            ss_prev_q    <= 1'b1;
            sck_meta_q   <= 1'b0;
            sck_sync_q   <= 1'b0;
            sck_prev_q   <= 1'b0;
            din_meta_q   <= 1'b0;
            din_sync_q   <= 1'b0;
            settle_q     <= 2'd0;
            armed_q      <= 1'b0;
            state_q      <= ST_IDLE;
            done_state_q <= ST_IDLE;
            byte_done_q  <= 1'b0;
            rx_shift_q   <= 8'h00;
            rx_byte_q    <= 8'h00;
            bit_cnt_q    <= 3'd0;
            target_q     <= 2'd0;
            tx_shift_q   <= 8'h00;
            strobe_q     <= 4'b0000;
            start_q      <= 1'b0;
            data_q       <= 8'h00;
`ifdef MCU_SPI_TIMEOUT_EN
            wd_q         <= 16'd0;
            frame_err_q  <= 1'b0;
`endif
        end else begin
            ss_meta_q  <= spi_io_ss;
            ss_sync_q  <= ss_meta_q;
            ss_prev_q  <= ss_sync_q;
            sck_meta_q <= spi_io_clk;
            sck_sync_q <= sck_meta_q;
            sck_prev_q <= sck_sync_q;
            din_meta_q <= spi_io_din;
            din_sync_q <= din_meta_q;

            if (settle_q != 2'd3) begin
                settle_q <= settle_q + 2'd1;
            end
            if ((settle_q == 2'd3) && ss_sync_q) begin
                armed_q <= 1'b1;
            end

            strobe_q    <= 4'b0000;
            start_q     <= 1'b0;
            byte_done_q <= 1'b0;
            tx_shift_q  <= tx_shift_d;

            // Receive. done_state_q remembers which slot the byte belongs
            // to, so the byte is still delivered if SS rises at the same time.
            if (rx_take) begin
                rx_shift_q <= rx_shift_d;
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_done_q  <= 1'b1;
                    rx_byte_q    <= rx_shift_d;
                    done_state_q <= state_q;
                end
            end

            // Completed byte handling, one cycle after the wrapping edge.
            if (byte_done_q) begin
                case (done_state_q)
                    ST_ADDR: begin
                        target_q <= rx_byte_q[1:0];
                        if (state_q == ST_ADDR) begin
                            state_q <= (rx_byte_q < 8'd4) ? ST_FIRST : ST_DROP;
                        end
                    end
                    ST_FIRST: begin
                        strobe_q <= target_onehot;
                        start_q  <= 1'b1;
                        data_q   <= rx_byte_q;
                        if (state_q == ST_FIRST) begin
                            state_q <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        strobe_q <= target_onehot;
                        start_q  <= 1'b0;
                        data_q   <= rx_byte_q;
                    end
                    default: ;
                endcase
            end

`ifdef MCU_SPI_TIMEOUT_EN
            frame_err_q <= 1'b0;
            if (wd_timeout) begin
                wd_q        <= 16'd0;
                bit_cnt_q   <= 3'd0;
                rx_shift_q  <= 8'h00;
                frame_err_q <= 1'b1;
                state_q     <= ST_DROP;
            end else if (!ss_sync_q && (bit_cnt_q != 3'd0) && (state_q != ST_IDLE)
                         && !sck_rise && !sck_fall) begin
                wd_q <= wd_q + 16'd1;
            end else begin
                wd_q <= 16'd0;
            end
`endif

            // Frame boundaries override everything above. SS release
            // discards any partial byte.
            if (ss_rise) begin
                state_q    <= ST_IDLE;
                bit_cnt_q  <= 3'd0;
                rx_shift_q <= 8'h00;
            end else if (ss_fall && armed_q && (state_q == ST_IDLE)) begin
                state_q <= ST_ADDR;
            end
        end
    end

    assign spi_io_dout    = tx_shift_q[7];
    assign data_in_strobe = strobe_q;
    assign data_in_start  = start_q;
    assign data_in        = data_q;

endmodule

// File: tb/tb_mcu_spi_target.sv
// -----------------------------------------------------------------------------
// tb_mcu_spi_target
// Directed bench for mcu_spi_target. It drives SPI frames bit by bit
// (SCK half period = 8 clk), watches the strobe bus with a monitor, and checks
// received bytes, strobe qualifiers and MISO replies against hand-computed
// values.
// -----------------------------------------------------------------------------
module tb_mcu_spi_target;

    logic       clk = 1'b0;
    logic       reset;
    logic       spi_io_ss, spi_io_clk, spi_io_din;
    logic       spi_io_dout;
    logic [3:0] data_in_strobe;
    logic       data_in_start;
    logic [7:0] data_in;
    logic [7:0] data_out0, data_out1, data_out2, data_out3;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    // Monitor state.
    int         strobe_cnt   = 0;
    int         multi_hot    = 0;
    int         ferr_cnt     = 0;
    logic [3:0] last_strobe  = 4'b0000;
    logic       last_start   = 1'b0;
    logic [7:0] last_data    = 8'h00;

    always #5 clk = ~clk;

    mcu_spi_target dut (
        .clk            (clk),
        .reset          (reset),
        .spi_io_ss      (spi_io_ss),
        .spi_io_clk     (spi_io_clk),
        .spi_io_din     (spi_io_din),
        .spi_io_dout    (spi_io_dout),
        .data_in_strobe (data_in_strobe),
        .data_in_start  (data_in_start),
        .data_in        (data_in),
        .data_out0      (data_out0),
        .data_out1      (data_out1),
        .data_out2      (data_out2),
        .data_out3      (data_out3),
        .frame_err      (frame_err)
    );

    always @(negedge clk) begin
        if (data_in_strobe != 4'b0000) begin
            strobe_cnt  = strobe_cnt + 1;
            last_strobe = data_in_strobe;
            last_start  = data_in_start;
            last_data   = data_in;
            if (!$onehot(data_in_strobe)) multi_hot = multi_hot + 1;
        end
        if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-18s observed 0x%0h expected 0x%0h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Shift out nbits of tx MSB first. Optionally release SS together with
    // the last rising edge. MISO is captured at each rising edge.
    task automatic spi_xfer(input logic [7:0] tx, input int nbits, input bit ss_with_last,
                            output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_io_din = tx[7-i];
            repeat (8) @(negedge clk);
            spi_io_clk = 1'b1;
            if (ss_with_last && (i == nbits - 1)) spi_io_ss = 1'b1;
            rx[7-i] = spi_io_dout;
            repeat (8) @(negedge clk);
            spi_io_clk = 1'b0;
        end
    endtask

    task automatic frame_open();
        spi_io_ss = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_close();
        repeat (8) @(negedge clk);
        spi_io_ss = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rx;
        int base;

        reset      = 1'b1;
        spi_io_ss  = 1'b1;
        spi_io_clk = 1'b0;
        spi_io_din = 1'b0;
        data_out0  = 8'h5C;
        data_out1  = 8'h11;
        data_out2  = 8'h22;
        data_out3  = 8'h33;
        repeat (5) @(negedge clk);

        check("rst_dout",   32'(spi_io_dout),    32'h0);
        check("rst_strobe", 32'(data_in_strobe), 32'h0);
        check("rst_start",  32'(data_in_start),  32'h0);
        check("rst_data",   32'(data_in),        32'h0);
        check("rst_ferr",   32'(frame_err),      32'h0);

        reset = 1'b0;
        repeat (10) @(negedge clk);

        // Frame 0x00,0x04,0x01 to target 0. The target replies 0x5C.
        base = strobe_cnt;
        frame_open();
        spi_xfer(8'h00, 8, 1'b0, rx);
        check("t0_b0_miso",  32'(rx), 32'h00);
        check("t0_b0_nostb", 32'(strobe_cnt - base), 32'd0);
        spi_xfer(8'h04, 8, 1'b0, rx);
        check("t0_b1_cnt",   32'(strobe_cnt - base), 32'd1);
        check("t0_b1_strobe", 32'(last_strobe), 32'b0001);
        check("t0_b1_start", 32'(last_start), 32'h1);
        check("t0_b1_data",  32'(last_data), 32'h04);
        check("t0_b1_miso",  32'(rx), 32'h5C);
        spi_xfer(8'h01, 8, 1'b0, rx);
        check("t0_b2_cnt",   32'(strobe_cnt - base), 32'd2);
        check("t0_b2_strobe", 32'(last_strobe), 32'b0001);
        check("t0_b2_start", 32'(last_start), 32'h0);
        check("t0_b2_data",  32'(last_data), 32'h01);
        check("t0_b2_miso",  32'(rx), 32'h5C);
        frame_close();

        // Out-of-range address: frame is dropped and MISO stays zero.
        base = strobe_cnt;
        frame_open();
        spi_xfer(8'h07, 8, 1'b0, rx);
        check("drop_b0_miso", 32'(rx), 32'h00);
        spi_xfer(8'hAA, 8, 1'b0, rx);
        check("drop_b1_miso", 32'(rx), 32'h00);
        spi_xfer(8'h55, 8, 1'b0, rx);
        check("drop_b2_miso", 32'(rx), 32'h00);
        frame_close();
        check("drop_nostb", 32'(strobe_cnt - base), 32'd0);

        // Partial byte discarded on SS release, then a clean frame to target 2.
        base = strobe_cnt;
        frame_open();
        spi_xfer(8'h01, 8, 1'b0, rx);
        spi_xfer(8'hF0, 5, 1'b0, rx);
        frame_close();
        check("part_nostb", 32'(strobe_cnt - base), 32'd0);
        frame_open();
        spi_xfer(8'h02, 8, 1'b0, rx);
        spi_xfer(8'h10, 8, 1'b0, rx);
        check("t2_cnt",    32'(strobe_cnt - base), 32'd1);
        check("t2_strobe", 32'(last_strobe), 32'b0100);
        check("t2_start",  32'(last_start), 32'h1);
        check("t2_data",   32'(last_data), 32'h10);
        check("t2_miso",   32'(rx), 32'h22);
        frame_close();

        // SS released together with the final SCK edge: the byte still strobes.
        base = strobe_cnt;
        frame_open();
        spi_xfer(8'h01, 8, 1'b0, rx);
        spi_xfer(8'h9A, 8, 1'b1, rx);
        repeat (20) @(negedge clk);
        check("ssedge_cnt",    32'(strobe_cnt - base), 32'd1);
        check("ssedge_strobe", 32'(last_strobe), 32'b0010);
        check("ssedge_data",   32'(last_data), 32'h9A);

        // Reset mid-byte with SS held low: ignore traffic until SS toggles.
        base = strobe_cnt;
        frame_open();
        spi_xfer(8'h01, 8, 1'b0, rx);
        spi_xfer(8'hFF, 3, 1'b0, rx);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        spi_xfer(8'h03, 8, 1'b0, rx);
        spi_xfer(8'h44, 8, 1'b0, rx);
        spi_xfer(8'h45, 8, 1'b0, rx);
        check("rstmid_nostb", 32'(strobe_cnt - base), 32'd0);
        frame_close();
        frame_open();
        spi_xfer(8'h03, 8, 1'b0, rx);
        spi_xfer(8'h44, 8, 1'b0, rx);
        check("t3_cnt",    32'(strobe_cnt - base), 32'd1);
        check("t3_strobe", 32'(last_strobe), 32'b1000);
        check("t3_start",  32'(last_start), 32'h1);
        check("t3_data",   32'(last_data), 32'h44);
        check("t3_miso",   32'(rx), 32'h33);
        frame_close();

`ifdef MCU_SPI_TIMEOUT_EN
        // Stall 3 bits into byte 1. One frame_err pulse, then DROP.
        check("to_pre_ferr", 32'(ferr_cnt), 32'd0);
        base = strobe_cnt;
        frame_open();
        spi_xfer(8'h01, 8, 1'b0, rx);
        spi_xfer(8'hFF, 3, 1'b0, rx);
        repeat (70000) @(negedge clk);
        check("to_ferr", 32'(ferr_cnt), 32'd1);
        check("to_nostb", 32'(strobe_cnt - base), 32'd0);
        spi_xfer(8'hFF, 5, 1'b0, rx);
        spi_xfer(8'h02, 8, 1'b0, rx);
        check("to_drop_nostb", 32'(strobe_cnt - base), 32'd0);
        check("to_drop_miso",  32'(rx), 32'h00);
        frame_close();
        check("to_ferr_once", 32'(ferr_cnt), 32'd1);
`else
        check("no_ferr", 32'(ferr_cnt), 32'd0);
`endif
        check("onehot", 32'(multi_hot), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
